wts_channel_sequencer: RTL and testbench
========================================

Name: wts_channel_sequencer

Overview:
- Parametrised, time-multiplexed channel sequencer for the wave table sound core.
- On a start pulse it walks a channel index 0..CHANNELS-1, one channel per clock.
- For each channel it selects that channel's register field and registers it, tagged with valid, channel number and last flag.
- Supports a hold (stall) input, a per-channel enable mask and arbitrary (non-power-of-two) channel counts. It feeds the per-channel mixer/accumulator.

Parameters:
- BITS, 8, width of each channel register field and of result.
- CHANNELS, 6, number of channels scanned (2..16).
- IDX_W, 3, width of the channel index; must satisfy 2**IDX_W >= CHANNELS.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin one scan; honoured only in IDLE.
- hold  input  1  stall; while high the scan does not advance or capture.
- ch_enable  input  CHANNELS  per-channel enable, snapshotted at start acceptance.
- reg_flat  input  CHANNELS*BITS  channel fields; channel k occupies bits [k*BITS +: BITS]; sampled live at capture.
- busy  output  1  high while the state is SCAN.
- active  output  IDX_W  index currently being selected; 0 in IDLE.
- result  output  BITS  registered selected field.
- result_ch  output  IDX_W  channel number of result.
- result_valid  output  1  result holds a new enabled-channel value this cycle.
- result_last  output  1  result corresponds to index CHANNELS-1; asserted regardless of enable.

Behaviour:
- Reset: state IDLE; active, result, result_ch = 0; busy, result_valid, result_last = 0; enable snapshot = 0. Reset has priority over every other input, including start in the same cycle and any in-progress scan (the scan is aborted with no result_last).
- IDLE: if start=1, the next state is SCAN, active=0 and the snapshot is set to ch_enable. Otherwise the block stays in IDLE.
- SCAN with hold=0, each cycle:
  - result <= sel(active); result_ch <= active.
  - result_valid <= snapshot[active]; result_last <= (active==CHANNELS-1).
  - If active==CHANNELS-1, the next state is IDLE and active becomes 0. Otherwise active increments by 1.
- SCAN with hold=1: active, result and result_ch keep their values; result_valid and result_last are forced to 0 next cycle. The skipped capture happens on the first cycle with hold=0.
- Disabled channels: the index is still consumed (one cycle). result is written with the field value, but result_valid=0.
- sel(k): returns field k for k<CHANNELS and 0 otherwise. Indices at or above CHANNELS are unreachable, but the mux default is 0.
- Latency: start at cycle T gives busy=1 from T+1 to T+CHANNELS (with no hold). Channel k's result appears at T+2+k. result_last is at T+CHANNELS+1, the same cycle busy is already 0.
- Outputs in IDLE: result_valid and result_last are 0 except for the single trailing capture cycle. result and result_ch hold their last values.
- start while in SCAN is ignored (not queued). start in the cycle busy first reads 0 after a scan (the result_last cycle) is accepted, giving back-to-back scans with no gap.
- ch_enable changes during a scan do not affect the current scan. reg_flat changes take effect at the next capture.

Decomposition:
- The shared wts package holds:
  - state encoding (ST_IDLE, ST_SCAN);
  - a helper constant function clog2 for deriving IDX_W;
  - the default channel count SCC_CHANNELS = 6.
- One sub-module: wts_field_mux (CHANNELS, BITS, IDX_W). It is a combinational indexed field select from reg_flat with a zero default, instantiated once for sel(active).
- FSM, counter and output registers stay in the top module.

Test Plan:
- Reset/idle (CHANNELS=6, BITS=8): reset high 3 cycles, then idle 5 cycles -> busy=0, active=0, result=0x00, result_valid=0, result_last=0 throughout.
- Full scan: reg_flat fields 0x10,0x21,0x32,0x43,0x54,0x65, ch_enable=6'h3F, start at T -> result 0x10..0x65 with result_ch 0..5 at T+2..T+7, result_valid=1 each cycle, result_last only at T+7, busy=1 at T+1..T+6.
- Mask: ch_enable=6'b101010, start -> result_valid=1 only for result_ch 1, 3, 5 (0x21, 0x43, 0x65). result_last still at result_ch 5. Toggling ch_enable mid-scan has no effect.
- Hold: hold=1 for 2 cycles while active=2 -> active stays 2; result_valid=0 for 2 cycles; 0x32 appears after hold drops; result_last is shifted by 2 cycles.
- Back-to-back/ignored start: start pulsed at T+3 (mid-scan) -> ignored. start at T+7 (result_last cycle) -> new scan, busy=1 at T+8, result_ch=0 at T+9.
- Reset mid-scan plus odd size (CHANNELS=5, IDX_W=3): reset at active=3 -> next cycle all outputs 0 with no result_last. Then a full scan -> result_last at result_ch 4, and active never exceeds 4.

Source files
------------

// File: rtl/wts_channel_sequencer_pkg.sv
// Shared definitions for the wave table sound channel sequencer:
// state encoding, default channel count and an index-width helper.
package wts_channel_sequencer_pkg;

  localparam int SCC_CHANNELS = 6;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

  // Smallest width w with 2**w >= n (minimum 1).
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++)
      if ((1 << r) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/wts_channel_sequencer_field_mux.sv
// Combinational indexed field select from a flat channel register bus.
// Indices without a backing channel return zero.
module wts_field_mux #(
  parameter int CHANNELS = 6,
  parameter int BITS     = 8,
  parameter int IDX_W    = 3
) (
  input  logic [CHANNELS*BITS-1:0] reg_flat,
  input  logic [IDX_W-1:0]         idx,
  output logic [BITS-1:0]          field
);

  always_comb begin
    field = '0;
    for (int k = 0; k < CHANNELS; k++)
      if (idx == IDX_W'(k)) field = reg_flat[k*BITS +: BITS];
  end

endmodule

// File: rtl/wts_channel_sequencer.sv
// Time-multiplexed channel sequencer: one start walks channels 0..CHANNELS-1,
// one per clock, registering each field with channel tag, valid and last flag.
module wts_channel_sequencer
  import wts_channel_sequencer_pkg::*;
#(
  parameter int BITS     = 8,
  parameter int CHANNELS = SCC_CHANNELS,
  parameter int IDX_W    = clog2(CHANNELS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     hold,
  input  logic [CHANNELS-1:0]      ch_enable,
  input  logic [CHANNELS*BITS-1:0] reg_flat,
  output logic                     busy,
  output logic [IDX_W-1:0]         active,
  output logic [BITS-1:0]          result,
  output logic [IDX_W-1:0]         result_ch,
  output logic                     result_valid,
  output logic                     result_last
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);

  logic [0:0]              state;
  logic [CHANNELS-1:0]     snap;
  logic [(1<<IDX_W)-1:0]   snap_ext;
  logic [BITS-1:0]         sel;

  // Pad the enable snapshot to the full index space so lookups never go out of range.
  always_comb begin
    snap_ext                 = '0;
    snap_ext[CHANNELS-1:0]   = snap;
  end

  wts_field_mux #(.CHANNELS(CHANNELS), .BITS(BITS), .IDX_W(IDX_W)) u_mux (
    .reg_flat (reg_flat),
    .idx      (active),
    .field    (sel)
  );

  assign busy = (state == ST_SCAN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      active       <= '0;
      snap         <= '0;
      result       <= '0;
      result_ch    <= '0;
      result_valid <= 1'b0;
      result_last  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          result_valid <= 1'b0;
          result_last  <= 1'b0;
          if (start) begin
            state  <= ST_SCAN;
            active <= '0;
            snap   <= ch_enable;
          end
        end
        default: begin
          if (hold) begin
            result_valid <= 1'b0;
            result_last  <= 1'b0;
          end else begin
            // Disabled channels still consume their slot; only valid is suppressed.
            result       <= sel;
            result_ch    <= active;
            result_valid <= snap_ext[active];
            result_last  <= (active == LAST_IDX);
            if (active == LAST_IDX) begin
              state  <= ST_IDLE;
              active <= '0;
            end else begin
              active <= active + 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wts_channel_sequencer.sv
// Scoreboard bench: stimulus pushes expected captures, negedge monitors pop and compare.
module tb_wts_channel_sequencer;

  typedef struct packed {
    logic [7:0] d;
    logic [2:0] ch;
    logic       v;
    logic       l;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst6, start6, hold6;
  logic [5:0]  en6;
  logic [47:0] flat6;
  logic        busy6, rv6, rl6;
  logic [2:0]  act6, rch6;
  logic [7:0]  res6;

  logic        rst5, start5, hold5;
  logic [4:0]  en5;
  logic [39:0] flat5;
  logic        busy5, rv5, rl5;
  logic [2:0]  act5, rch5;
  logic [7:0]  res5;

  exp_t q6[$];
  exp_t q5[$];
  exp_t e6, e5;
  int n_cmp = 0;
  int n_err = 0;

  wts_channel_sequencer #(.BITS(8), .CHANNELS(6), .IDX_W(3)) dut6 (
    .clk(clk), .reset(rst6), .start(start6), .hold(hold6), .ch_enable(en6),
    .reg_flat(flat6), .busy(busy6), .active(act6), .result(res6),
    .result_ch(rch6), .result_valid(rv6), .result_last(rl6)
  );

  wts_channel_sequencer #(.BITS(8), .CHANNELS(5), .IDX_W(3)) dut5 (
    .clk(clk), .reset(rst5), .start(start5), .hold(hold5), .ch_enable(en5),
    .reg_flat(flat5), .busy(busy5), .active(act5), .result(res5),
    .result_ch(rch5), .result_valid(rv5), .result_last(rl5)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] f6(input int k);
    return 8'h10 + 8'(k * 8'h11);
  endfunction

  function automatic logic [7:0] f5(input int k);
    return 8'hA0 + 8'(k * 8'h11);
  endfunction

  task automatic push6(input logic [7:0] d, input int ch, input logic v, input logic l);
    q6.push_back({d, 3'(ch), v, l});
  endtask

  task automatic push5(input logic [7:0] d, input int ch, input logic v, input logic l);
    q5.push_back({d, 3'(ch), v, l});
  endtask

  always @(negedge clk) begin
    if (rv6 || rl6) begin
      if (q6.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL dut6_unexpected: got %h expected nothing", {res6, rch6, rv6, rl6});
      end else begin
        e6 = q6.pop_front();
        chk("dut6_result", 32'({res6, rch6, rv6, rl6}), 32'(e6));
      end
    end
  end

  always @(negedge clk) begin
    if (rv5 || rl5) begin
      if (q5.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL dut5_unexpected: got %h expected nothing", {res5, rch5, rv5, rl5});
      end else begin
        e5 = q5.pop_front();
        chk("dut5_result", 32'({res5, rch5, rv5, rl5}), 32'(e5));
      end
    end
  end

  initial begin
    rst6 = 1'b1; start6 = 1'b0; hold6 = 1'b0; en6 = '0;
    rst5 = 1'b1; start5 = 1'b0; hold5 = 1'b0; en5 = '0;
    flat6 = {8'h65, 8'h54, 8'h43, 8'h32, 8'h21, 8'h10};
    flat5 = {8'hE4, 8'hD3, 8'hC2, 8'hB1, 8'hA0};

    // reset then idle: everything quiet
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_state", 32'({busy6, act6, res6, rv6, rl6}), 32'd0);
    end
    rst6 = 1'b0; rst5 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_state", 32'({busy6, act6, res6, rv6, rl6}), 32'd0);
    end

    // full scan, all enabled
    en6 = 6'h3F;
    for (int k = 0; k < 6; k++) push6(f6(k), k, 1'b1, k == 5);
    start6 = 1'b1; tick(); start6 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk("scan_busy_active", 32'({busy6, act6}), 32'({1'b1, 3'(k)}));
      tick();
    end
    chk("last_busy_low", 32'({busy6, rl6}), 32'b01);
    tick();

    // enable mask, toggled mid-scan
    en6 = 6'b101010;
    push6(8'h21, 1, 1'b1, 1'b0);
    push6(8'h43, 3, 1'b1, 1'b0);
    push6(8'h65, 5, 1'b1, 1'b1);
    start6 = 1'b1; tick(); start6 = 1'b0;
    en6 = 6'h3F;
    tick();
    en6 = 6'h00;
    repeat (6) tick();

    // ignored mid-scan start, then back-to-back start on the last cycle
    en6 = 6'h3F;
    for (int k = 0; k < 6; k++) push6(f6(k), k, 1'b1, k == 5);
    start6 = 1'b1; tick(); start6 = 1'b0;
    tick(); tick();
    start6 = 1'b1; tick(); start6 = 1'b0;
    tick(); tick(); tick();
    chk("b2b_last_cycle", 32'({busy6, rl6, rch6}), 32'({1'b0, 1'b1, 3'd5}));
    en6 = 6'b000011;
    push6(8'h10, 0, 1'b1, 1'b0);
    push6(8'h21, 1, 1'b1, 1'b0);
    push6(8'h65, 5, 1'b0, 1'b1);
    start6 = 1'b1; tick(); start6 = 1'b0;
    chk("b2b_busy", 32'({busy6, act6}), 32'({1'b1, 3'd0}));
    tick();
    chk("b2b_first_result", 32'({rch6, rv6, res6}), 32'({3'd0, 1'b1, 8'h10}));
    repeat (6) tick();

    // hold for two cycles while active=2
    en6 = 6'h3F;
    for (int k = 0; k < 6; k++) push6(f6(k), k, 1'b1, k == 5);
    start6 = 1'b1; tick(); start6 = 1'b0;
    tick(); tick();
    chk("hold_pre_active", 32'(act6), 32'd2);
    hold6 = 1'b1;
    tick();
    chk("hold_cycle1", 32'({busy6, act6, res6, rv6, rl6}), 32'({1'b1, 3'd2, 8'h21, 1'b0, 1'b0}));
    tick();
    chk("hold_cycle2", 32'({busy6, act6, res6, rv6, rl6}), 32'({1'b1, 3'd2, 8'h21, 1'b0, 1'b0}));
    hold6 = 1'b0;
    tick();
    chk("hold_release", 32'({res6, rch6, rv6}), 32'({8'h32, 3'd2, 1'b1}));
    repeat (3) tick();
    chk("hold_last_shift", 32'({rl6, rch6, busy6}), 32'({1'b1, 3'd5, 1'b0}));
    repeat (2) tick();

    // CHANNELS=5: reset mid-scan at active=3
    en5 = 5'h1F;
    for (int k = 0; k < 3; k++) push5(f5(k), k, 1'b1, 1'b0);
    start5 = 1'b1; tick(); start5 = 1'b0;
    tick(); tick(); tick();
    chk("odd_pre_reset_active", 32'(act5), 32'd3);
    rst5 = 1'b1; tick();
    chk("odd_reset_abort", 32'({busy5, act5, res5, rch5, rv5, rl5}), 32'd0);
    rst5 = 1'b0; tick();

    for (int k = 0; k < 5; k++) push5(f5(k), k, 1'b1, k == 4);
    start5 = 1'b1; tick(); start5 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("odd_active_bound", 32'(act5 <= 3'd4), 32'd1);
      tick();
    end

    repeat (3) tick();
    chk("q6_drained", 32'(q6.size()), 32'd0);
    chk("q5_drained", 32'(q5.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
